// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: IDLE -> COUNTDOWN -> PLAY -> GAME_OVER, game tick, mole picking and hit strobes.
// Optional pause input and freeze behaviour are compiled in with `define WHACK_PAUSE_EN.
module whack_game_ctrl #(
  parameter int NUM_MOLES       = 4,
  parameter int TICK_DIV        = 50_000_000,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int GAME_TICKS      = 60,
  parameter int MOLE_TICKS      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef WHACK_PAUSE_EN
  input  logic                 pause,
`endif
  input  logic [NUM_MOLES-1:0] btn,
  output logic [NUM_MOLES-1:0] mole,
  output logic                 score_clear,
  output logic                 score_enable,
  output logic                 hit_pulse,
  output logic [7:0]           time_left,
  output logic [1:0]           state
);

  localparam int IW = $clog2(NUM_MOLES);
  localparam int TW = $clog2(TICK_DIV);
  localparam int MW = $clog2(MOLE_TICKS + 1);
  localparam logic [NUM_MOLES-1:0] ONE = NUM_MOLES'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNTDOWN = 2'd1, PLAY = 2'd2, GAME_OVER = 2'd3} state_t;

  state_t               st, st_n;
  logic [7:0]           lfsr;
  logic [NUM_MOLES-1:0] btn_q, edges, mole_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [7:0]           cd_cnt, cd_n, time_n;
  logic [MW-1:0]        mole_tmr, tmr_n;
  logic [IW-1:0]        last_idx, idx_n, rnd_idx, new_idx;
  logic                 tick, hit, paused, pause_lvl;
  logic                 hit_n, clr_n, sen_n;

`ifdef WHACK_PAUSE_EN
  assign pause_lvl = pause;
  assign paused    = pause && (st == COUNTDOWN || st == PLAY);
`else
  assign pause_lvl = 1'b0;
  assign paused    = 1'b0;
`endif

  assign state   = st;
  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
  assign edges   = btn & ~btn_q;
  assign hit     = (st == PLAY) && !paused && |(edges & mole);
  assign rnd_idx = lfsr[IW-1:0];
  // Bump past the previous mole so the same one never lights twice in a row.
  assign new_idx = (rnd_idx == last_idx) ? rnd_idx + IW'(1) : rnd_idx;

  always_comb begin
    st_n       = st;
    tick_cnt_n = paused ? tick_cnt : (tick ? '0 : tick_cnt + TW'(1));
    cd_n       = cd_cnt;
    time_n     = time_left;
    tmr_n      = mole_tmr;
    mole_n     = mole;
    idx_n      = last_idx;
    hit_n      = 1'b0;
    clr_n      = 1'b0;
    case (st)
      IDLE, GAME_OVER: begin
        if (start) begin
          st_n       = COUNTDOWN;
          clr_n      = 1'b1;
          cd_n       = 8'(COUNTDOWN_TICKS);
          tick_cnt_n = '0;
        end
      end
      COUNTDOWN: begin
        if (tick && !paused) begin
          if (cd_cnt <= 8'd1) begin
            st_n       = PLAY;
            cd_n       = 8'd0;
            time_n     = 8'(GAME_TICKS);
            tmr_n      = MW'(MOLE_TICKS);
            mole_n     = ONE << rnd_idx;
            idx_n      = rnd_idx;
            tick_cnt_n = '0;
          end else begin
            cd_n = cd_cnt - 8'd1;
          end
        end
      end
      PLAY: begin
        if (tick && !paused) begin
          if (time_left <= 8'd1) begin
            // Final tick: any coincident hit is dropped.
            st_n   = GAME_OVER;
            time_n = 8'd0;
            mole_n = '0;
          end else begin
            time_n = time_left - 8'd1;
            if (hit) begin
              hit_n  = 1'b1;
              mole_n = '0;
            end else if (mole_tmr <= MW'(1) || mole == '0) begin
              mole_n = ONE << new_idx;
              idx_n  = new_idx;
              tmr_n  = MW'(MOLE_TICKS);
            end else begin
              tmr_n = mole_tmr - MW'(1);
            end
          end
        end else if (hit) begin
          hit_n  = 1'b1;
          mole_n = '0;
        end
      end
      default: st_n = IDLE;
    endcase
    sen_n = (st_n == PLAY) && !pause_lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr         <= 8'hA5;
      btn_q        <= '0;
      tick_cnt     <= '0;
      cd_cnt       <= '0;
      time_left    <= '0;
      mole_tmr     <= '0;
      mole         <= '0;
      last_idx     <= '0;
      hit_pulse    <= 1'b0;
      score_clear  <= 1'b0;
      score_enable <= 1'b0;
    end else begin
      lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      btn_q        <= btn;
      tick_cnt     <= tick_cnt_n;
      cd_cnt       <= cd_n;
      time_left    <= time_n;
      mole_tmr     <= tmr_n;
      mole         <= mole_n;
      last_idx     <= idx_n;
      hit_pulse    <= hit_n;
      score_clear  <= clr_n;
      score_enable <= sen_n;
    end
  end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl with TICK_DIV=4, COUNTDOWN_TICKS=2, GAME_TICKS=5, MOLE_TICKS=2, NUM_MOLES=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_whack_game_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] btn = 4'b0;
  logic [3:0] mole;
  logic       score_clear, score_enable, hit_pulse;
  logic [7:0] time_left;
  logic [1:0] state;
  int         passed = 0, total = 0;
  logic [3:0] m_hit, m_cur, m_prev;

  whack_game_ctrl #(
    .NUM_MOLES(4), .TICK_DIV(4), .COUNTDOWN_TICKS(2), .GAME_TICKS(5), .MOLE_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef WHACK_PAUSE_EN
    .pause(pause),
`endif
    .btn(btn), .mole(mole), .score_clear(score_clear), .score_enable(score_enable),
    .hit_pulse(hit_pulse), .time_left(time_left), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int idx_of(input logic [3:0] m);
    int r = 0;
    for (int i = 0; i < 4; i++) if (m[i]) r = i;
    return r;
  endfunction

  task automatic start_game();
    start = 1'b1;
    step();
    chk("start_state", 32'(state), 1);
    chk("start_clear", 32'(score_clear), 1);
    start = 1'b0;
    repeat (8) step();
    chk("play_entry", 32'(state), 2);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_mole", 32'(mole), 0);
    chk("rst_time", 32'(time_left), 0);
    chk("rst_outs", {29'b0, score_clear, score_enable, hit_pulse}, 0);
    rst_n = 1'b1;
    step();

    // start: clear pulse, countdown of 2 ticks x 4 cycles, PLAY after 9 edges incl. the sampling one
    start = 1'b1;
    step();
    chk("cd_state", 32'(state), 1);
    chk("cd_clear", 32'(score_clear), 1);
    start = 1'b0;
    step();
    chk("cd_clear_1cyc", 32'(score_clear), 0);
    repeat (6) step();
    chk("cd_still", 32'(state), 1);
    step();
    chk("play_state", 32'(state), 2);
    chk("play_time", 32'(time_left), 5);
    chk("play_sen", 32'(score_enable), 1);
    // LFSR A5 stepped 9 times -> 8'h9D, low bits 01
    chk("first_mole", 32'(mole), 32'h2);

    // hit on lit mole, then hold
    step();
    btn = mole; m_hit = mole;
    step();
    chk("hit_pulse", 32'(hit_pulse), 1);
    chk("hit_mole_clr", 32'(mole), 0);
    chk("hit_sen", 32'(score_enable), 1);
    step();
    chk("hold_no_retrig", 32'(hit_pulse), 0);
    step();
    chk("tick1_time", 32'(time_left), 4);
    chk("tick1_onehot", 32'($onehot(mole)), 1);
    chk("no_repeat_hit", 32'(mole != m_hit), 1);

    // unlit button alone, then lit + unlit together
    m_cur = mole;
    btn = 4'(1 << ((idx_of(m_cur) + 1) % 4));
    step();
    chk("wrong_no_hit", 32'(hit_pulse), 0);
    chk("wrong_mole_kept", 32'(mole), 32'(m_cur));
    btn = 4'b0;
    step();
    btn = m_cur | 4'(1 << ((idx_of(m_cur) + 2) % 4));
    step();
    chk("mixed_hit", 32'(hit_pulse), 1);
    chk("mixed_mole_clr", 32'(mole), 0);
    btn = 4'b0;
    step();
    chk("mixed_single", 32'(hit_pulse), 0);
    chk("tick2_time", 32'(time_left), 3);
    chk("tick2_onehot", 32'($onehot(mole)), 1);

    // hit edge coincident with a tick
    repeat (3) step();
    btn = mole;
    step();
    chk("tickhit_pulse", 32'(hit_pulse), 1);
    chk("tickhit_mole", 32'(mole), 0);
    chk("tickhit_time", 32'(time_left), 2);
    btn = 4'b0;
    repeat (4) step();
    chk("tick4_time", 32'(time_left), 1);
    chk("tick4_onehot", 32'($onehot(mole)), 1);

    // hit edge coincident with the final tick is dropped
    repeat (3) step();
    btn = mole;
    step();
    chk("final_no_hit", 32'(hit_pulse), 0);
    chk("final_state", 32'(state), 3);
    chk("final_time", 32'(time_left), 0);
    chk("final_mole", 32'(mole), 0);
    chk("final_sen", 32'(score_enable), 0);
    btn = 4'b0;
    step();
    chk("final_no_late_hit", 32'(hit_pulse), 0);

    // second game with no presses: 20 cycles of PLAY, moles never repeat
    start_game();
    m_prev = mole;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 8 || i == 16) chk("mole_change", 32'(mole != m_prev && mole != 4'b0), 1);
      if (i == 19) begin
        chk("len_state19", 32'(state), 2);
        chk("len_time19", 32'(time_left), 1);
      end
      if (i == 20) begin
        chk("len_state20", 32'(state), 3);
        chk("len_time20", 32'(time_left), 0);
        chk("len_mole20", 32'(mole), 0);
        chk("len_sen20", 32'(score_enable), 0);
      end
      m_prev = mole;
    end

    // asynchronous reset mid-PLAY
    step();
    start_game();
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_mole", 32'(mole), 0);
    chk("arst_time", 32'(time_left), 0);
    chk("arst_outs", {29'b0, score_clear, score_enable, hit_pulse}, 0);
    step();
    rst_n = 1'b1;
    step();

`ifdef WHACK_PAUSE_EN
    // pause for 12 cycles: time frozen, hits ignored, end delayed by 12
    start_game();
    step();
    pause = 1'b1;
    repeat (4) step();
    btn = mole; m_cur = mole;
    step();
    chk("pause_no_hit", 32'(hit_pulse), 0);
    chk("pause_mole", 32'(mole), 32'(m_cur));
    chk("pause_sen", 32'(score_enable), 0);
    btn = 4'b0;
    repeat (7) step();
    chk("pause_time", 32'(time_left), 5);
    chk("pause_state", 32'(state), 2);
    pause = 1'b0;
    repeat (18) step();
    chk("pause_len_state", 32'(state), 2);
    chk("pause_len_time", 32'(time_left), 1);
    step();
    chk("pause_end", 32'(state), 3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
